// File: rtl/pipe_mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM encodings, default
// memory timeout and the MEM/WB register layout.
package pipe_mem_stage_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } mwb_t;

  // A bubble keeps the datapath fields but can no longer write the register file.
  function automatic mwb_t mwb_bubble(input mwb_t cur);
    mwb_t b;
    b       = cur;
    b.wreg  = 1'b0;
    b.m2reg = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register; the next value (load or bubble) is chosen by
// the MEM stage that instantiates it.
module pipemwreg
  import pipe_mem_stage_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  mwb_t wb_d,
  output mwb_t wb_q
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: issues one data-memory request per aligned load/store, stalls
// the upstream pipeline until ack or timeout, and feeds the MEM/WB register.
module pipe_mem_stage
  import pipe_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          fault_q, fault_d;
  logic          stall;
  mwb_t          wb_q, wb_d;

  logic mem_op, aligned, timeout_hit;

  assign mem_op      = mm2reg | mwmem;
  assign aligned     = (malu[1:0] == 2'b00);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fault_d = 1'b0;
    wb_d    = wb_q;
    stall   = 1'b0;

    if (state_q == ST_IDLE) begin
      if (!mem_op) begin
        wb_d.wreg  = mwreg;
        wb_d.m2reg = mm2reg;
        wb_d.alu   = malu;
        wb_d.rn    = mrn;
      end else if (!aligned) begin
        wb_d    = mwb_bubble(wb_q);
        fault_d = 1'b1;
      end else begin
        stall   = 1'b1;
        state_d = ST_BUSY;
        cnt_d   = '0;
        req_d   = 1'b1;
        we_d    = mwmem;
        addr_d  = malu;
        wdata_d = mb;
        wb_d    = mwb_bubble(wb_q);
      end
    end else begin
      // Ack is tested first so a reply in the last allowed cycle is not a fault.
      if (dmem_ack) begin
        wb_d    = '{wreg: mwreg, m2reg: mm2reg, mo: dmem_rdata, alu: malu, rn: mrn};
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end else if (timeout_hit) begin
        wb_d    = mwb_bubble(wb_q);
        req_d   = 1'b0;
        we_d    = 1'b0;
        fault_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        stall = 1'b1;
        wb_d  = mwb_bubble(wb_q);
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  pipemwreg u_mwreg (
    .clock (clock),
    .reset (reset),
    .wb_d  (wb_d),
    .wb_q  (wb_q)
  );

  // The pipeline must not be frozen while reset is held.
  assign mem_stall  = stall & ~reset;
  assign mem_fault  = fault_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wwreg      = wb_q.wreg;
  assign wm2reg     = wb_q.m2reg;
  assign wmo        = wb_q.mo;
  assign walu       = wb_q.alu;
  assign wrn        = wb_q.rn;

endmodule
